// File: rtl/alu_operand_stage.sv
// Operand-select and pipeline stage between register-file read and the ALU,
// with a 2-entry skid buffer and flush. Build option: ALU_OPERAND_FWD_EN enables writeback forwarding.
module alu_operand_stage #(
  parameter int DATA_W = 16,
  parameter int IMM_W  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] rd_q,
  input  logic [DATA_W-1:0] rs_q,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [DATA_W-1:0] pc,
  input  logic [IMM_W-1:0]  imm,
  input  logic [1:0]        a_sel,
  input  logic [1:0]        b_sel,
  input  logic              flush,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b
);

  logic [DATA_W-1:0] rd_eff;
  logic [DATA_W-1:0] rs_eff;
  logic [DATA_W-1:0] imm_sext;
  logic [DATA_W-1:0] imm_zext;
  logic [DATA_W-1:0] a_new;
  logic [DATA_W-1:0] b_new;

  logic              out_valid_reg;
  logic              skid_valid_reg;
  logic [DATA_W-1:0] alu_a_reg;
  logic [DATA_W-1:0] alu_b_reg;
  logic [DATA_W-1:0] skid_a_reg;
  logic [DATA_W-1:0] skid_b_reg;

  logic              accept;
  logic              out_free;

`ifdef ALU_OPERAND_FWD_EN
  // Bypass a same-cycle writeback that the register file has not yet absorbed.
  assign rd_eff = (wb_valid && (wb_addr == rd_addr)) ? wb_data : rd_q;
  assign rs_eff = (wb_valid && (wb_addr == rs_addr)) ? wb_data : rs_q;
`else
  logic unused_fwd;
  assign unused_fwd = ^{wb_valid, wb_addr, wb_data, rd_addr, rs_addr};
  assign rd_eff = rd_q;
  assign rs_eff = rs_q;
`endif

  // Bit-wise extension keeps IMM_W == DATA_W legal without zero-width replication.
  genvar gi;
  generate
    for (gi = 0; gi < DATA_W; gi++) begin : g_ext
      if (gi < IMM_W) begin : g_low
        assign imm_sext[gi] = imm[gi];
        assign imm_zext[gi] = imm[gi];
      end else begin : g_high
        assign imm_sext[gi] = imm[IMM_W-1];
        assign imm_zext[gi] = 1'b0;
      end
    end
  endgenerate

  always_comb begin
    a_new = rd_eff;
    unique case (a_sel)
      2'd0: a_new = rd_eff;
      2'd1: a_new = pc;
      2'd2: a_new = '0;
      2'd3: a_new = rs_eff;
      default: a_new = rd_eff;
    endcase
  end

  always_comb begin
    b_new = imm_sext;
    unique case (b_sel)
      2'd0: b_new = imm_sext;
      2'd1: b_new = rs_eff;
      2'd2: b_new = imm_zext;
      2'd3: b_new = DATA_W'(1);
      default: b_new = imm_sext;
    endcase
  end

  assign in_ready = ~skid_valid_reg;
  assign accept   = in_valid & in_ready;
  assign out_free = ~out_valid_reg | out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_reg  <= 1'b0;
      skid_valid_reg <= 1'b0;
      alu_a_reg      <= '0;
      alu_b_reg      <= '0;
      skid_a_reg     <= '0;
      skid_b_reg     <= '0;
    end else if (flush) begin
      out_valid_reg  <= 1'b0;
      skid_valid_reg <= 1'b0;
    end else if (skid_valid_reg) begin
      // in_ready is low here, so the only possible move is skid -> output.
      if (out_ready) begin
        alu_a_reg      <= skid_a_reg;
        alu_b_reg      <= skid_b_reg;
        skid_valid_reg <= 1'b0;
      end
    end else if (accept) begin
      if (out_free) begin
        alu_a_reg     <= a_new;
        alu_b_reg     <= b_new;
        out_valid_reg <= 1'b1;
      end else begin
        skid_a_reg     <= a_new;
        skid_b_reg     <= b_new;
        skid_valid_reg <= 1'b1;
      end
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_valid = out_valid_reg;
  assign alu_a     = alu_a_reg;
  assign alu_b     = alu_b_reg;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage: driver queues expected operands, a
// negedge monitor checks each output handshake against the queue.
module tb_alu_operand_stage;
  localparam int DATA_W = 16;
  localparam int IMM_W  = 8;
  localparam int ADDR_W = 3;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] rd_q;
  logic [DATA_W-1:0] rs_q;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] rs_addr;
  logic [DATA_W-1:0] pc;
  logic [IMM_W-1:0]  imm;
  logic [1:0]        a_sel;
  logic [1:0]        b_sel;
  logic              flush;
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;

  int n_tests = 0;
  int n_fail  = 0;
  logic [2*DATA_W-1:0] exp_q[$];

  alu_operand_stage #(.DATA_W(DATA_W), .IMM_W(IMM_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .rd_q(rd_q), .rs_q(rs_q), .rd_addr(rd_addr), .rs_addr(rs_addr),
    .pc(pc), .imm(imm), .a_sel(a_sel), .b_sel(b_sel), .flush(flush),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .alu_a(alu_a), .alu_b(alu_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Monitor: a transfer happens at the next posedge when both are high.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 32'(alu_a), 32'hFFFF_FFFF);
      end else begin
        logic [2*DATA_W-1:0] e;
        e = exp_q.pop_front();
        check("sb_alu_a", 32'(alu_a), 32'(e[2*DATA_W-1:DATA_W]));
        check("sb_alu_b", 32'(alu_b), 32'(e[DATA_W-1:0]));
      end
    end
  end

  task automatic send(input logic [DATA_W-1:0] t_rd, input logic [DATA_W-1:0] t_rs,
                      input logic [DATA_W-1:0] t_pc, input logic [IMM_W-1:0] t_imm,
                      input logic [1:0] t_as, input logic [1:0] t_bs,
                      input logic [DATA_W-1:0] ea, input logic [DATA_W-1:0] eb);
    int n;
    n = 0;
    rd_q = t_rd; rs_q = t_rs; pc = t_pc; imm = t_imm; a_sel = t_as; b_sel = t_bs;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) check("in_ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    exp_q.push_back({ea, eb});
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; in_valid = 1'b0; rd_q = '0; rs_q = '0; rd_addr = '0; rs_addr = '0;
    pc = '0; imm = '0; a_sel = '0; b_sel = '0; flush = 1'b0;
    wb_valid = 1'b0; wb_addr = '0; wb_data = '0; out_ready = 1'b1;
    #12;
    check("rst_alu_a", 32'(alu_a), 32'h0);
    check("rst_alu_b", 32'(alu_b), 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h1);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // Operand selection, one-cycle latency
    send(16'h1234, 16'h5555, 16'h0042, 8'h80, 2'd0, 2'd0, 16'h1234, 16'hFF80);
    check("latency_out_valid", 32'(out_valid), 32'h1);
    send(16'h1234, 16'h5555, 16'h0042, 8'h80, 2'd0, 2'd2, 16'h1234, 16'h0080);
    send(16'h1234, 16'h5555, 16'h0042, 8'h80, 2'd0, 2'd3, 16'h1234, 16'h0001);
    send(16'h1234, 16'h5555, 16'h0042, 8'h7F, 2'd1, 2'd0, 16'h0042, 16'h007F);
    send(16'h1234, 16'h5555, 16'h0042, 8'h01, 2'd2, 2'd1, 16'h0000, 16'h5555);
    send(16'h1234, 16'hA5A5, 16'h0042, 8'hFF, 2'd3, 2'd2, 16'hA5A5, 16'h00FF);
    drain();
    @(posedge clk); #1;
    check("idle_out_valid", 32'(out_valid), 32'h0);

    // Back-pressure: E1 on output, E2 in skid
    out_ready = 1'b0;
    send(16'h1111, 16'h0, 16'h0, 8'h02, 2'd0, 2'd0, 16'h1111, 16'h0002);
    check("bp_in_ready_e1", 32'(in_ready), 32'h1);
    send(16'h2222, 16'h0, 16'h0, 8'h03, 2'd0, 2'd0, 16'h2222, 16'h0003);
    check("bp_in_ready_e2", 32'(in_ready), 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check("bp_hold_alu_a", 32'(alu_a), 32'h1111);
    check("bp_hold_valid", 32'(out_valid), 32'h1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_skid_move_a", 32'(alu_a), 32'h2222);
    check("bp_in_ready_free", 32'(in_ready), 32'h1);
    @(posedge clk); #1;
    check("bp_empty_valid", 32'(out_valid), 32'h0);
    check("bp_queue_empty", 32'(exp_q.size()), 32'd0);

    // Flush with both entries held and an incoming entry
    out_ready = 1'b0;
    send(16'h3333, 16'h0, 16'h0, 8'h00, 2'd0, 2'd0, 16'h3333, 16'h0000);
    send(16'h4444, 16'h0, 16'h0, 8'h00, 2'd0, 2'd0, 16'h4444, 16'h0000);
    rd_q = 16'h5A5A; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    check("flush_out_valid", 32'(out_valid), 32'h0);
    check("flush_in_ready", 32'(in_ready), 32'h1);
    // Flush while accept is possible: entry must be discarded
    in_valid = 1'b1; flush = 1'b1; rd_q = 16'h6666;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_accept_drop", 32'(out_valid), 32'h0);
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("flush_stays_empty", 32'(out_valid), 32'h0);

    // Forwarding
    rd_addr = 3'd3; rs_addr = 3'd5; wb_valid = 1'b1; wb_addr = 3'd3; wb_data = 16'hBEEF;
`ifdef ALU_OPERAND_FWD_EN
    send(16'h0000, 16'h0007, 16'h0, 8'h00, 2'd0, 2'd1, 16'hBEEF, 16'h0007);
    rs_addr = 3'd3;
    send(16'h0000, 16'h0007, 16'h0, 8'h00, 2'd3, 2'd1, 16'hBEEF, 16'hBEEF);
`else
    send(16'h0000, 16'h0007, 16'h0, 8'h00, 2'd0, 2'd1, 16'h0000, 16'h0007);
    rs_addr = 3'd3;
    send(16'h0000, 16'h0007, 16'h0, 8'h00, 2'd3, 2'd1, 16'h0007, 16'h0007);
`endif
    wb_valid = 1'b0;
    drain();

    // Asynchronous reset with output and skid full
    out_ready = 1'b0;
    send(16'h7777, 16'h0, 16'h0, 8'h11, 2'd0, 2'd0, 16'h7777, 16'h0011);
    send(16'h8888, 16'h0, 16'h0, 8'h22, 2'd0, 2'd0, 16'h8888, 16'h0022);
    check("pre_rst_skid_full", 32'(in_ready), 32'h0);
    #2;
    rst = 1'b0;
    #1;
    exp_q.delete();
    check("arst_out_valid", 32'(out_valid), 32'h0);
    check("arst_alu_a", 32'(alu_a), 32'h0);
    check("arst_alu_b", 32'(alu_b), 32'h0);
    check("arst_in_ready", 32'(in_ready), 32'h1);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(16'h9999, 16'h0, 16'h0, 8'hC0, 2'd0, 2'd0, 16'h9999, 16'hFFC0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
Parametrised operand-select and pipeline stage between register-file read and the ALU.
- Builds ALU operands A and B from register data, PC or immediates using per-operand select codes.
- Registers the operands behind a valid/ready handshake with a 2-entry skid buffer, so back-pressure from the ALU never drops an instruction.
- Supports synchronous flush for branch redirects.

Parameters:
DATA_W, 16, operand/datapath width in bits
IMM_W, 8, immediate field width (IMM_W <= DATA_W)
ADDR_W, 3, register address width (used for forwarding compare)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-low reset
in_valid  input  1  upstream has a decoded instruction
in_ready  output  1  stage can accept this cycle
rd_q  input  DATA_W  register-file data, destination/first operand
rs_q  input  DATA_W  register-file data, source operand
rd_addr  input  ADDR_W  register address of rd_q
rs_addr  input  ADDR_W  register address of rs_q
pc  input  DATA_W  PC of the instruction
imm  input  IMM_W  immediate/offset field
a_sel  input  2  A select: 0 rd, 1 pc, 2 zero, 3 rs
b_sel  input  2  B select: 0 sign-ext imm, 1 rs, 2 zero-ext imm, 3 constant 1
flush  input  1  discard all held and incoming entries
wb_valid  input  1  writeback result valid (forwarding)
wb_addr  input  ADDR_W  writeback register address
wb_data  input  DATA_W  writeback data
out_valid  output  1  alu_a/alu_b hold a valid entry
out_ready  input  1  ALU consumes the entry this cycle
alu_a  output  DATA_W  registered operand A
alu_b  output  DATA_W  registered operand B

Behaviour:
- Reset (rst low, async): alu_a=0, alu_b=0, out_valid=0, skid empty, in_ready=1.
- in_ready is a registered signal, equal to NOT skid_valid. It does not depend combinationally on out_ready.
- Accept occurs when in_valid and in_ready are both high on a rising edge.
- Operands are computed from the inputs in the accept cycle.
  - Sign-extend: imm[IMM_W-1] is replicated into the upper DATA_W-IMM_W bits.
  - Zero-extend: the upper DATA_W-IMM_W bits are 0.
  - Constant 1: the value 1, width DATA_W.
- Latency: an entry accepted in cycle N is presented on the output in cycle N+1 if the output register is free.
- The output register is free when out_valid=0, or when out_valid=1 and out_ready=1 in that cycle.
- Accept cases:
  - Output register free: the new entry loads the output register and out_valid=1.
  - Output register full and not consumed: the new entry loads the skid register and skid_valid=1, so in_ready=0 next cycle.
- Consume with skid full: the skid entry moves to the output register and skid_valid=0. No accept can occur in this cycle because in_ready=0.
- Consume with no accept and skid empty: out_valid=0. alu_a/alu_b hold their last values.
- Simultaneous accept and consume with skid empty: the new entry goes to the output register and out_valid stays 1.
- While out_valid=1 and out_ready=0, alu_a/alu_b are stable.
- Flush (synchronous):
  - Next cycle out_valid=0 and skid_valid=0, so in_ready=1.
  - Any accept in the flush cycle is discarded.
  - Flush takes priority over accept and over consume.
  - Data registers are not cleared.
- Reset asserted mid-operation: all valid state clears immediately and any entry in flight is lost.
- Order: entries leave in acceptance order. No entry is duplicated or dropped without a flush.

Optional Feature:
Macro ALU_OPERAND_FWD_EN.
- Defined:
  - In the accept cycle, if wb_valid=1 and wb_addr==rd_addr, wb_data replaces rd_q.
  - If wb_valid=1 and wb_addr==rs_addr, wb_data replaces rs_q.
  - The substitution is applied before operand selection, for every select that uses rd or rs.
  - Entries already held in the output or skid register are not updated.
- Not defined: the wb_* ports are present but ignored, and rd_addr/rs_addr are unused.

Test Plan:
- Reset, then in_valid=1, a_sel=0, b_sel=0, rd_q=0x1234, imm=0x80, out_ready=1 -> next cycle out_valid=1, alu_a=0x1234, alu_b=0xFF80.
- b_sel=2 with imm=0x80, then b_sel=3 -> alu_b=0x0080, then alu_b=0x0001. With a_sel=1 and pc=0x0042 -> alu_a=0x0042.
- Hold out_ready=0 and issue entries E1, E2 -> E1 held on the output, E2 in skid, in_ready=0. Raise out_ready -> E1 then E2 on consecutive cycles, then in_ready=1.
- Both entries held, then flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the incoming entry does not appear.
- Defined build: rd_addr=3, wb_valid=1, wb_addr=3, wb_data=0xBEEF, rd_q=0x0000, a_sel=0 -> alu_a=0xBEEF. Same stimulus in a non-defined build -> alu_a=0x0000.
- Drive rst low while out_valid=1 and skid full -> out_valid=0, alu_a=alu_b=0, in_ready=1 immediately.
